// File: rtl/usart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : usart_rx
// Description : Oversampling 8N1 serial receiver. Recovers frames of
//               start + DATA_BITS data (LSB first) + one stop bit from rx_pin,
//               timed by ticks derived from the rising edges of serial_clock.
//               Received words are handed to the consumer through a
//               valid/ack holding register with sticky framing and overrun
//               flags.
// Ports       : clock          - system clock, rising edge
//               reset_n        - asynchronous active-low reset
//               serial_clock   - oversample clock, one tick per rising edge
//               rx_pin         - serial line, idle high, asynchronous
//               rx_data        - last good received word
//               rx_valid       - rx_data holds an unconsumed word
//               rx_ack         - consumer takes rx_data when high with rx_valid
//               clear_errors   - clears both sticky error flags
//               framing_error  - sticky, a stop bit was sampled low
//               overrun_error  - sticky, a good word was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module usart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 serial_clock,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    input  logic                 clear_errors,
    output logic                 framing_error,
    output logic                 overrun_error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_TICK_W-1:0] c_HALF_LAST = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_BIT_LAST  = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_START   = 3'd1;
    localparam logic [2:0] c_ST_DATA    = 3'd2;
    localparam logic [2:0] c_ST_STOP    = 3'd3;
    localparam logic [2:0] c_ST_RECOVER = 3'd4;

    // ------------------------------------------------------------------------
    // Synchronizers and tick generation
    // ------------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_sc_meta;
    logic r_sc_sync;
    logic r_sc_prev;
    logic r_tick;

    // The line flops reset high so a reset release never looks like a start
    // bit. The tick is registered, so it is high during the cycle after the
    // third clock edge following a serial_clock rise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_sc_meta <= 1'b0;
            r_sc_sync <= 1'b0;
            r_sc_prev <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_rx_meta <= rx_pin;
            r_rx_sync <= r_rx_meta;
            r_sc_meta <= serial_clock;
            r_sc_sync <= r_sc_meta;
            r_sc_prev <= r_sc_sync;
            r_tick    <= r_sc_sync & ~r_sc_prev;
        end
    end

    // ------------------------------------------------------------------------
    // Receive FSM and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_framing;
    logic                 r_overrun;

    logic w_half_reached;
    logic w_bit_end;

    logic w_cnt_clr;
    logic w_cnt_inc;
    logic w_bit_clr;
    logic w_bit_inc;
    logic w_shift_en;
    logic w_stop_good;
    logic w_stop_bad;
    logic w_overrun;

    assign w_half_reached = (r_tick_cnt == c_HALF_LAST);
    assign w_bit_end      = (r_tick_cnt == c_BIT_LAST);

    // New bits enter at the MSB end so the first (LSB) bit ends up in bit 0
    // once all DATA_BITS samples have been taken.
    generate
        if (DATA_BITS > 1) begin : g_shift_multi
            assign w_shift_next = {r_rx_sync, r_shift[DATA_BITS-1:1]};
        end else begin : g_shift_single
            assign w_shift_next = r_rx_sync;
        end
    endgenerate

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the FSM only moves on tick cycles
    always_comb begin
        w_state_next = r_state;
        if (r_tick) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!r_rx_sync) begin
                        w_state_next = c_ST_START;
                    end
                end
                c_ST_START: begin
                    // A start bit that is high again at mid-bit was a glitch
                    if (w_half_reached) begin
                        w_state_next = r_rx_sync ? c_ST_IDLE : c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end && (r_bit_cnt == c_DATA_LAST)) begin
                        w_state_next = c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    // Re-arming at mid-stop lets back-to-back frames through;
                    // a low stop bit waits in RECOVER for the line to idle so
                    // a break is not taken as a stream of start bits.
                    if (w_bit_end) begin
                        w_state_next = r_rx_sync ? c_ST_IDLE : c_ST_RECOVER;
                    end
                end
                c_ST_RECOVER: begin
                    if (r_rx_sync) begin
                        w_state_next = c_ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = c_ST_IDLE;
                end
            endcase
        end
    end

    // Output / control strobes
    always_comb begin
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_bit_clr   = 1'b0;
        w_bit_inc   = 1'b0;
        w_shift_en  = 1'b0;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        if (r_tick) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_cnt_clr = ~r_rx_sync;
                end
                c_ST_START: begin
                    if (w_half_reached) begin
                        w_cnt_clr = ~r_rx_sync;
                        w_bit_clr = ~r_rx_sync;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        w_cnt_clr  = 1'b1;
                        w_shift_en = 1'b1;
                        w_bit_inc  = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        w_stop_good = r_rx_sync;
                        w_stop_bad  = ~r_rx_sync;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                default: begin
                    w_cnt_clr = 1'b0;
                end
            endcase
        end
    end

    // A good frame that finds the holding register still full and not being
    // acked in the same cycle is dropped.
    assign w_overrun = w_stop_good & r_valid & ~rx_ack;

    // Counters and shift register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            if (w_cnt_clr) begin
                r_tick_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
            end

            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
            end

            if (w_shift_en) begin
                r_shift <= w_shift_next;
            end
        end
    end

    // Holding register and sticky flags; set conditions win over clears
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_framing <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_stop_good && !w_overrun) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ack) begin
                r_valid <= 1'b0;
            end

            if (w_stop_bad) begin
                r_framing <= 1'b1;
            end else if (clear_errors) begin
                r_framing <= 1'b0;
            end

            if (w_overrun) begin
                r_overrun <= 1'b1;
            end else if (clear_errors) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign framing_error = r_framing;
    assign overrun_error = r_overrun;

endmodule
`default_nettype wire

// File: doc/usart_rx.md
# usart_rx

Serial receiver paired with `usart_tx`; it consumes the line that `usart_tx` drives on `tx_pin`. It recovers 8N1 frames (start, DATA_BITS data LSB-first, one stop) by oversampling `rx_pin` at ticks derived from `serial_clock`. Received bytes are presented to the CPU-side logic through a valid/ack holding register with sticky framing and overrun flags.

## Interface

- `DATA_BITS`, 8: data bits per frame.
- `OVERSAMPLE`, 16: serial_clock ticks per bit period; must be even and at least 4.

- `clock` in 1: system clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `serial_clock` in 1: oversample clock; each rising edge is one tick; high and low phases each at least 2 `clock` periods.
- `rx_pin` in 1: serial line, idle high, asynchronous to `clock`.
- `rx_data` out DATA_BITS: last good received word.
- `rx_valid` out 1: `rx_data` holds an unconsumed word.
- `rx_ack` in 1: consumer takes `rx_data` when high together with `rx_valid`.
- `clear_errors` in 1: clears both error flags.
- `framing_error` out 1: sticky; a stop bit was sampled low.
- `overrun_error` out 1: sticky; a good frame completed while `rx_valid` was high and not acked.

## Operation

- `rx_pin` passes through a 2-flop synchronizer. Both flops reset to 1.
- `serial_clock` passes through a 2-flop synchronizer and an edge register. `tick` is asserted for exactly one `clock` cycle per rising edge.
- All FSM activity happens only on `tick` cycles. `tick_cnt` is log2(OVERSAMPLE) bits wide. `bit_cnt` counts 0..DATA_BITS-1.
- **IDLE:** on a tick with the synced line low, set `tick_cnt` to 0 and go to START.
- **START:** count ticks. On the tick where `tick_cnt` reaches OVERSAMPLE/2-1, sample the line at mid-bit:
  - line high: glitch, go to IDLE with no flag.
  - line low: clear `tick_cnt` and `bit_cnt`, go to DATA.
- **DATA:** every OVERSAMPLE ticks, sample the line and shift it into the shift register from the MSB end, so the word ends up LSB-first. After sampling bit DATA_BITS-1, go to STOP.
- **STOP:** after OVERSAMPLE ticks, sample the line.
  - High: the frame is good. Load `rx_data` and set `rx_valid`. If `rx_valid` was already 1 and `rx_ack` is not high in the same cycle, set `overrun_error` and leave `rx_data` unchanged (the new word is dropped). Go to IDLE.
  - Low: set `framing_error`, drop the word, go to RECOVER.
- **RECOVER:** on a tick with the line high, go to IDLE. This prevents a break condition from being seen as repeated start bits.
- `rx_ack` while `rx_valid` is high clears `rx_valid` on the next edge. `rx_ack` while `rx_valid` is low is ignored.
- `clear_errors` clears both flags. If a set condition occurs in the same cycle, the set wins.

## Timing

- Reset values: `rx_data`=0, `rx_valid`=0, `framing_error`=0, `overrun_error`=0. FSM=IDLE, counters=0.
- `reset_n` asserted mid-frame aborts the frame immediately (asynchronous), with all outputs at their reset values. After release, the next falling edge starts a new frame.
- `tick` goes high on the 3rd `clock` edge after a `serial_clock` rise.
- Start edge to mid-start sample is OVERSAMPLE/2 ticks. Successive data samples are OVERSAMPLE ticks apart. The stop sample is OVERSAMPLE ticks after the last data sample.
- `rx_valid` and `framing_error` rise on the `clock` edge ending the stop-sample tick cycle.
- A frame completing in the same cycle as `rx_ack`: the new word loads, `rx_valid` stays 1, no overrun.
- Frame length is (DATA_BITS+2)×OVERSAMPLE ticks nominal. The receiver re-arms at mid-stop, so back-to-back frames are accepted.

## Test plan

- **Reset:** `reset_n`=0 with `rx_pin`=1 for 5 clocks → all outputs 0. After release, 40 ticks of idle line → `rx_valid` stays 0.
- **Good frame:** send 0xAA (line 0,0,1,0,1,0,1,0,1,1), 16 ticks per bit → `rx_data`=0xAA and `rx_valid`=1 one clock after the stop-sample tick. Pulse `rx_ack` → `rx_valid`=0 on the next edge.
- **Glitch:** drive `rx_pin` low for 4 ticks, then high → FSM returns to IDLE, `rx_valid`=0, no error. A following 0x3C frame is received correctly.
- **Framing error:** send 0x55 with the stop bit low and hold the line low 30 ticks → `framing_error`=1, `rx_valid`=0. Release the line high, then send 0x3C → `rx_data`=0x3C. `clear_errors` → `framing_error`=0.
- **Overrun:** send 0x12 then 0x34 back-to-back with no ack → `rx_data`=0x12, `overrun_error`=1. Repeat with `rx_ack` pulsed in the same cycle that 0x34 completes → `rx_data`=0x34, no overrun.
- **Reset mid-frame:** assert `reset_n` low during data bit 3 of 0xFF → outputs reset. Then send 0xC3 → `rx_data`=0xC3, no errors.
